// File: rtl/ec_point_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ec_point_encoder
// Description : Streaming SEC1 elliptic-curve point encoder. Latches affine
//               X/Y for a run-time-selected curve, range-checks them against
//               the curve byte size and emits 0x00, 0x02/0x03||X or
//               0x04||X||Y as a big-endian byte stream over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module ec_point_encoder #(
    parameter int MAX_BYTES = 66,
    parameter int CB0       = 32,
    parameter int CB1       = 48,
    parameter int CB2       = 66
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             curve_sel,
    input  logic                   compress,
    input  logic                   infinity,
    input  logic [MAX_BYTES*8-1:0] x_in,
    input  logic [MAX_BYTES*8-1:0] y_in,
    output logic                   busy,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_code
);

    localparam int c_IW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_CHECK  = 3'd1;
    localparam logic [2:0] c_S_PREFIX = 3'd2;
    localparam logic [2:0] c_S_XB     = 3'd3;
    localparam logic [2:0] c_S_YB     = 3'd4;
    localparam logic [2:0] c_S_DONE   = 3'd5;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [1:0]      r_curve;
    logic            r_compress;
    logic            r_inf;
    logic [7:0]      r_xb [MAX_BYTES];
    logic [7:0]      r_yb [MAX_BYTES];
    logic [c_IW-1:0] r_idx;
    logic            r_err;
    logic [1:0]      r_err_code;

    logic [15:0]     w_cb;
    logic [c_IW-1:0] w_cb_m1;
    logic            w_bad_curve;
    logic            w_x_oor;
    logic            w_y_oor;
    logic            w_range_err;
    logic            w_idx_zero;
    logic            w_accept;

    assign w_accept   = (r_state == c_S_IDLE) && start;
    assign w_idx_zero = (r_idx == '0);

    // Curve byte size lookup; reserved selector maps to 0 and is rejected.
    always_comb begin
        w_cb = 16'd0;
        case (r_curve)
            2'd0:    w_cb = 16'(CB0);
            2'd1:    w_cb = 16'(CB1);
            2'd2:    w_cb = 16'(CB2);
            default: w_cb = 16'd0;
        endcase
    end

    assign w_cb_m1     = c_IW'(w_cb - 16'd1);
    assign w_bad_curve = (w_cb == 16'd0) || (w_cb > 16'(MAX_BYTES));

    // Any nonzero byte above the curve size means the coordinate does not fit.
    always_comb begin
        w_x_oor = 1'b0;
        w_y_oor = 1'b0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (16'(i) >= w_cb) begin
                if (r_xb[i] != 8'h00) w_x_oor = 1'b1;
                if (r_yb[i] != 8'h00) w_y_oor = 1'b1;
            end
        end
    end

    assign w_range_err = w_x_oor || (!r_compress && w_y_oor);

    // Request capture; inputs are frozen from the accept edge until IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_curve    <= 2'd0;
            r_compress <= 1'b0;
            r_inf      <= 1'b0;
        end else if (w_accept) begin
            r_curve    <= curve_sel;
            r_compress <= compress;
            r_inf      <= infinity;
        end
    end

    // Coordinate byte lanes, stored LSB-first (lane 0 = least significant).
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
                r_xb[i] <= x_in[i*8 +: 8];
                r_yb[i] <= y_in[i*8 +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; out_valid is high in PREFIX/XB/YB so out_ready alone marks a transfer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE:   if (start) w_next = c_S_CHECK;
            c_S_CHECK: begin
                if (w_bad_curve)      w_next = c_S_IDLE;
                else if (r_inf)       w_next = c_S_PREFIX;
                else if (w_range_err) w_next = c_S_IDLE;
                else                  w_next = c_S_PREFIX;
            end
            c_S_PREFIX: if (out_ready) w_next = r_inf ? c_S_DONE : c_S_XB;
            c_S_XB:     if (out_ready && w_idx_zero) w_next = r_compress ? c_S_DONE : c_S_YB;
            c_S_YB:     if (out_ready && w_idx_zero) w_next = c_S_DONE;
            c_S_DONE:   w_next = c_S_IDLE;
            default:    w_next = c_S_IDLE;
        endcase
    end

    // Byte index walks CB-1 down to 0 for each coordinate, reloaded on entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else begin
            case (r_state)
                c_S_PREFIX: if (out_ready) r_idx <= w_cb_m1;
                c_S_XB:     if (out_ready) r_idx <= w_idx_zero ? w_cb_m1 : r_idx - 1'b1;
                c_S_YB:     if (out_ready && !w_idx_zero) r_idx <= r_idx - 1'b1;
                default:    ;
            endcase
        end
    end

    // Error pulse follows CHECK; the code persists until the next accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            r_err <= 1'b0;
            if (w_accept) r_err_code <= 2'd0;
            if (r_state == c_S_CHECK) begin
                if (w_bad_curve) begin
                    r_err      <= 1'b1;
                    r_err_code <= 2'd1;
                end else if (!r_inf && w_range_err) begin
                    r_err      <= 1'b1;
                    r_err_code <= 2'd2;
                end
            end
        end
    end

    assign err      = r_err;
    assign err_code = r_err_code;

    // Stream outputs decoded from state; stable while stalled since only a transfer moves state/idx.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 8'h00;
        case (r_state)
            c_S_CHECK: busy = 1'b1;
            c_S_PREFIX: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = r_inf;
                if (r_inf)           out_data = 8'h00;
                else if (r_compress) out_data = {7'h01, r_yb[0][0]};
                else                 out_data = 8'h04;
            end
            c_S_XB: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = r_xb[r_idx];
                out_last  = r_compress && w_idx_zero;
            end
            c_S_YB: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = r_yb[r_idx];
                out_last  = w_idx_zero;
            end
            c_S_DONE: done = 1'b1;
            default:  ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/ec_point_encoder.md
Name: ec_point_encoder

Overview:
- Streaming SEC1 elliptic-curve point encoder for the ecc key path.
- Latches affine coordinates X/Y for a run-time-selected curve and emits the SEC1 octet encoding as a byte stream with valid/ready handshake.
- Supported encodings: uncompressed (0x04||X||Y), compressed (0x02/0x03||X) and point-at-infinity (0x00).
- Each coordinate is left-padded to the curve byte size and range-checked against it; this is the hardware counterpart of the software point_2_buf / bn2binpad path, generalised over curve size and encoding mode.

Parameters:
- MAX_BYTES, 66, width of the coordinate input buses in bytes; must be >= every enabled curve size.
- CB0, 32, coordinate byte size for curve_sel=0 (P-256).
- CB1, 48, coordinate byte size for curve_sel=1 (P-384).
- CB2, 66, coordinate byte size for curve_sel=2 (P-521).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- curve_sel  in  2  0/1/2 select CB0/CB1/CB2; 3 is reserved
- compress  in  1  1 = compressed encoding
- infinity  in  1  1 = encode point at infinity
- x_in  in  MAX_BYTES*8  X coordinate, unsigned, LSB-aligned
- y_in  in  MAX_BYTES*8  Y coordinate, unsigned, LSB-aligned
- busy  out  1  high from the start-accept cycle until done/err
- out_data  out  8  encoded byte
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts the byte
- out_last  out  1  marks the final byte of the encoding
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on a rejected request
- err_code  out  2  0 none, 1 bad curve, 2 coordinate out of range; held until the next start

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - busy, out_valid, out_last, done and err go to 0; out_data=0x00; err_code=0.
  - Reset mid-stream aborts the current encoding; no further bytes are emitted.
- States and transitions:
  - IDLE: start=1 latches curve_sel, compress, infinity, x_in and y_in; busy=1; go to CHECK. start while busy is ignored.
  - CHECK (1 cycle): CB = table[curve_sel].
    - curve_sel=3, or CB > MAX_BYTES: err_code=1, err pulse, go to IDLE.
    - infinity=1: skip the range check, go to PREFIX.
    - Any nonzero byte at index >= CB in X or Y (Y checked only when uncompressed): err_code=2, err pulse, go to IDLE.
    - Otherwise go to PREFIX.
  - PREFIX: out_valid=1, out_data = 0x00 if infinity, 0x02|Y[0] if compress, else 0x04. out_last=1 only for infinity.
    - On handshake: infinity goes to DONE, otherwise to XB with idx=CB-1.
  - XB: out_data = X byte[idx], big-endian (most significant byte first).
    - Each handshake decrements idx.
    - At idx=0: compressed sets out_last=1 and goes to DONE; uncompressed goes to YB with idx=CB-1.
  - YB: same as XB for Y; out_last=1 at idx=0; then DONE.
  - DONE: done pulse for one cycle, busy=0, go to IDLE.
- Handshake:
  - A transfer occurs when out_valid & out_ready are both high.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - out_valid never drops without a transfer, except on reset.
  - Back-to-back transfers run at 1 byte/cycle.
- Lengths: infinity 1 byte; compressed 1+CB bytes; uncompressed 1+2*CB bytes.
- Latency: first byte is valid 2 cycles after the start-accept edge (CHECK, then PREFIX).
- Counter: idx is sized clog2(MAX_BYTES) and never wraps; it is reloaded on entry to XB/YB.
- Errors: err and done are mutually exclusive, and no bytes are emitted on error.
- Input hold: after start, changes on x_in, y_in and the mode inputs have no effect until the next IDLE.

Test Plan:
- P-256 uncompressed: X=0x01..0x20, Y=0x21..0x40, out_ready=1 -> 65 bytes: 0x04, 0x20..0x01, 0x40..0x21; out_last on byte 65; done 1 cycle later.
- P-384 compressed: Y LSB=1, X=0xAB repeated -> 49 bytes: 0x03 then 48×0xAB; repeat with Y LSB=0 -> first byte 0x02.
- P-521 padding: X=0x1FF, Y=0x1 -> 133 bytes: 0x04, 64×0x00, 0x01, 0xFF, 65×0x00, 0x01.
- Range/curve errors:
  - P-256 with X byte[32]=0x01 -> err pulse, err_code=2, zero bytes emitted.
  - curve_sel=3 -> err_code=1.
- Backpressure: out_ready toggled randomly during P-256 uncompressed -> the byte sequence is identical to the out_ready=1 run and out_data is stable while stalled.
- Infinity and reset:
  - infinity=1 -> single byte 0x00 with out_last=1, then done.
  - rst_n low on byte 10 of a P-384 stream -> out_valid=0 and busy=0 next cycle; a new start then produces a full 97-byte stream.
